fft_bitrev_buffer: RTL and testbench
====================================

# fft_bitrev_buffer

Parametrised ping-pong frame buffer between the streaming FFT core and its sample source/sink. It accepts N-point frames of packed complex samples on a valid/ready input and replays each frame on a valid/ready output in natural or bit-reversed order, selectable per frame. It also flags the last sample of every frame. It replaces the fixed 32-bit, fixed-length reorder path in the FFT top level.

## Interface

Parameters:
- LOG2N, 3: log2 of frame length N; legal range 2..12.
- DATA_W, 32: sample width; packed {re[DATA_W/2-1:0], im[DATA_W/2-1:0]}, must be even.

Ports:
- i_clk, in, 1: single clock; all logic on rising edge.
- i_rst_n, in, 1: reset, synchronous, active-low.
- i_data_valid, in, 1: input sample valid.
- i_data, in, DATA_W: input sample.
- o_data_ready, out, 1: buffer can accept a sample this cycle.
- i_bitrev, in, 1: output order for the frame whose first sample is accepted this cycle; 1 = bit-reversed, 0 = natural.
- o_data_valid, out, 1: output sample valid.
- o_data, out, DATA_W: output sample.
- o_last, out, 1: high with the final (N-th) output sample of a frame.
- i_data_ready, in, 1: downstream accepts output this cycle.

## Operation

- Storage: two banks of N words each, bank[b][0..N-1]. Per-bank state: full[b] and mode[b].
- Write side:
  - wr_bank and wr_idx (LOG2N bits) start at 0.
  - o_data_ready = !full[wr_bank], decoded combinationally from registers only, with no path from i_data_valid.
  - On accept (i_data_valid && o_data_ready), i_data is written to bank[wr_bank][wr_idx] and wr_idx increments.
  - When wr_idx == 0 on accept, i_bitrev is latched into mode[wr_bank].
  - When wr_idx == N-1 on accept: full[wr_bank] is set, wr_idx wraps to 0, and wr_bank toggles.
- Read side:
  - rd_bank and rd_idx start at 0.
  - Read address = mode[rd_bank] ? bit-reverse(rd_idx) : rd_idx, over LOG2N bits.
  - Output register load condition: full[rd_bank] && (!o_data_valid || i_data_ready) && the frame is not exhausted.
  - On load: o_data is loaded from the addressed word, o_data_valid is set, o_last is set to (rd_idx == N-1), and rd_idx increments.
  - On loading rd_idx == N-1: full[rd_bank] clears, rd_idx wraps to 0, and rd_bank toggles.
  - When the load condition is false and i_data_ready is high, o_data_valid clears.
- Output holding: o_data, o_data_valid and o_last stay stable while o_data_valid && !i_data_ready. This is AXI-stream rule: no retraction, no change.
- Boundary conditions:
  - Both banks full: o_data_ready is low until the read side frees the current write bank.
  - Simultaneous free (read clears full[b]) and fill (write sets full[other]) on the same edge: both take effect. o_data_ready for the freed bank is high the next cycle.
  - A write never targets the bank being read, because full[wr_bank] gates it.
  - i_bitrev is ignored except on the first sample of a frame.
  - Frames with fewer than N samples stay pending indefinitely. There is no timeout.
- Reset (i_rst_n low at an edge), including mid-frame:
  - Clears full[], mode[], wr_bank, wr_idx, rd_bank and rd_idx.
  - Clears o_data_valid and o_last. o_data is set to 0.
  - Partial frames are discarded. RAM contents are not cleared.
  - o_data_ready is 1 in the first cycle after reset is released.

## Timing

- Reset values: o_data_ready = 1 (combinational, from full[0] = 0), o_data_valid = 0, o_last = 0, o_data = 0.
- Latency: if the last sample of a frame is accepted at edge E, full is set at E and the output register loads at E+1. o_data_valid is therefore high in the cycle after E+1.
- Throughput:
  - Input sustains 1 sample/cycle across frame boundaries while the other bank is free.
  - Output sustains 1 sample/cycle across frames when the next bank is already full.
- No combinational path from input to output. o_data_ready depends only on registers.

## Structure

- Shared package fft_pkg holds:
  - the sample-packing helpers: re/im field width DATA_W/2;
  - the bitrev function, parameterised by LOG2N.
- One sub-module, fft_bank_ram: a simple dual-port RAM (one write port, one read port) of depth 2N, addressed {bank, idx}, with asynchronous read feeding the output register. This maps to distributed RAM.
- Pointer/flag logic and the output register stay in fft_bitrev_buffer.

## Test plan

Default parameters (N = 8) unless noted.

1. **Bit-reversed order:** reset, then stream 0..7 with i_bitrev = 1 and i_data_ready = 1 → output order 0,4,2,6,1,5,3,7; o_last only on the 7; first o_data_valid two cycles after the last input accept.
2. **Natural order, back-to-back:** stream 0..7 with i_bitrev = 0, then 8..15 with i_bitrev = 1, no gaps → outputs 0..7, then 8,12,10,14,9,13,11,15, no idle cycles between frames; o_data_ready never drops.
3. **Back-pressure:** hold i_data_ready = 0 and stream 24 samples → o_data_ready falls after the 16th accept; o_data_valid held with o_data = 0 stable; on release, 16 samples drain in order and o_data_ready rises.
4. **Random stalls:** random i_data_valid/i_data_ready over 100 frames → output matches the reference reorder model; o_data never changes while valid && !ready.
5. **Mid-frame reset:** assert i_rst_n = 0 after 5 samples of a frame and after 3 outputs of a frame → o_data_valid = 0, o_last = 0, o_data_ready = 1; the next full frame 0..7 is reordered correctly.
6. **Parameter sweep:** LOG2N = 4, DATA_W = 16, stream 0..15 with i_bitrev = 1 → 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder path.
//
// Contents:
//   MAX_LOG2N / MAX_DATA_W : largest frame exponent and sample width the helpers handle
//   bitrev()               : reverse the low log2n bits of an index
//   pack_sample()          : build a packed {re, im} sample of width data_w
//   sample_re/sample_im()  : extract the real/imaginary halves of a packed sample
package fft_pkg;

  localparam int unsigned MAX_LOG2N  = 12;
  localparam int unsigned MAX_DATA_W = 64;

  // Reverses the low log2n bits of idx; bits above log2n come back as zero.
  // The low bit of the shifted value is pushed into the result log2n times,
  // so the lowest input bit ends up as the highest result bit.
  function automatic logic [MAX_LOG2N-1:0] bitrev(
    input logic [MAX_LOG2N-1:0] idx,
    input int unsigned          log2n
  );
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] v;
    r = '0;
    v = idx;
    for (int i = 0; i < int'(MAX_LOG2N); i++) begin
      if (i < int'(log2n)) begin
        r = {r[MAX_LOG2N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Packs re into the upper half and im into the lower half of a data_w sample.
  function automatic logic [MAX_DATA_W-1:0] pack_sample(
    input logic [MAX_DATA_W/2-1:0] re,
    input logic [MAX_DATA_W/2-1:0] im,
    input int unsigned             data_w
  );
    logic [MAX_DATA_W-1:0] mask;
    mask = (MAX_DATA_W'(1) << (data_w / 2)) - MAX_DATA_W'(1);
    return ((MAX_DATA_W'(re) & mask) << (data_w / 2)) | (MAX_DATA_W'(im) & mask);
  endfunction

  function automatic logic [MAX_DATA_W/2-1:0] sample_re(
    input logic [MAX_DATA_W-1:0] s,
    input int unsigned           data_w
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] t;
    mask = (MAX_DATA_W'(1) << (data_w / 2)) - MAX_DATA_W'(1);
    t    = (s >> (data_w / 2)) & mask;
    return t[MAX_DATA_W/2-1:0];
  endfunction

  function automatic logic [MAX_DATA_W/2-1:0] sample_im(
    input logic [MAX_DATA_W-1:0] s,
    input int unsigned           data_w
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] t;
    mask = (MAX_DATA_W'(1) << (data_w / 2)) - MAX_DATA_W'(1);
    t    = s & mask;
    return t[MAX_DATA_W/2-1:0];
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Simple dual-port sample store holding both ping-pong banks.
// Address is {bank, idx}. Write is synchronous, read is asynchronous so the
// addressed word can be captured directly by the output register.
//
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address {bank, idx}
//   wr_data : word to write
//   rd_addr : read address {bank, idx}
//   rd_data : word at rd_addr (combinational)
module fft_bank_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset: contents are don't-care until a frame has been written.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer that replays each N-point frame in natural or
// bit-reversed order (chosen by i_bitrev on the first sample of the frame)
// and marks the last output sample of every frame.
//
// Handshakes (both sides): a beat transfers on a rising edge where valid and
// ready are both high. The producer holds valid and data stable until that
// edge; ready may come and go freely. o_data_ready is decoded from registers
// only, and the output side is a register, so no combinational path runs
// from any input to any output.
//
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_data_valid   : input sample valid
//   i_data         : input sample {re, im}
//   o_data_ready   : buffer accepts a sample this cycle
//   i_bitrev       : order for the frame starting this cycle (1 = bit-reversed)
//   o_data_valid   : output sample valid
//   o_data         : output sample
//   o_last         : final sample of a frame
//   i_data_ready   : downstream accepts the output this cycle
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  input  logic              i_bitrev,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_data_ready
);

  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  // Per-bank state: full marks a complete frame waiting to be read,
  // mode holds the order selected for that frame.
  logic [1:0]        full;
  logic [1:0]        mode;

  logic              wr_bank;
  logic [LOG2N-1:0]  wr_idx;
  logic              rd_bank;
  logic [LOG2N-1:0]  rd_idx;
  logic [LOG2N-1:0]  rd_addr;

  logic              wr_en;
  logic              wr_done;
  logic              load;
  logic              rd_done;
  logic [DATA_W-1:0] ram_rdata;

  assign o_data_ready = ~full[wr_bank];
  assign wr_en        = i_data_valid & o_data_ready;
  assign wr_done      = wr_en & (wr_idx == IDX_LAST);

  // full[rd_bank] already implies the frame is not exhausted: it clears on
  // the load of the final index.
  assign load    = full[rd_bank] & (~o_data_valid | i_data_ready);
  assign rd_done = load & (rd_idx == IDX_LAST);

  assign rd_addr = mode[rd_bank] ? LOG2N'(bitrev(MAX_LOG2N'(rd_idx), LOG2N))
                                 : rd_idx;

  fft_bank_ram #(
    .ADDR_W (LOG2N + 1),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (i_data),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (ram_rdata)
  );

  // Write pointer and per-bank order flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      mode    <= '0;
    end else if (wr_en) begin
      if (wr_idx == '0) begin
        mode[wr_bank] <= i_bitrev;
      end
      wr_idx <= wr_idx + 1'b1;
      if (wr_idx == IDX_LAST) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Fill and free can land on the same edge; they always address different
  // banks because a write needs !full and a read needs full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full <= '0;
    end else begin
      if (wr_done) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read pointer and output register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
      o_data       <= '0;
    end else if (load) begin
      o_data       <= ram_rdata;
      o_data_valid <= 1'b1;
      o_last       <= (rd_idx == IDX_LAST);
      rd_idx       <= rd_idx + 1'b1;
      if (rd_idx == IDX_LAST) begin
        rd_bank <= ~rd_bank;
      end
    end else if (i_data_ready) begin
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
module tb_fft_bitrev_buffer;
  import fft_pkg::*;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int DW    = 32;
  localparam int TMO   = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          in_bitrev;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;

  fft_bitrev_buffer #(.LOG2N(LOG2N), .DATA_W(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_valid (in_valid),
    .i_data       (in_data),
    .o_data_ready (in_ready),
    .i_bitrev     (in_bitrev),
    .o_data_valid (out_valid),
    .o_data       (out_data),
    .o_last       (out_last),
    .i_data_ready (out_ready)
  );

  // second instance for the larger-frame, narrower-sample configuration
  logic        b_rst_n;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_in_ready;
  logic        b_bitrev;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic        b_out_last;
  logic        b_out_ready;

  fft_bitrev_buffer #(.LOG2N(4), .DATA_W(16)) dut_b (
    .i_clk        (clk),
    .i_rst_n      (b_rst_n),
    .i_data_valid (b_valid),
    .i_data       (b_data),
    .o_data_ready (b_in_ready),
    .i_bitrev     (b_bitrev),
    .o_data_valid (b_out_valid),
    .o_data       (b_out_data),
    .o_last       (b_out_last),
    .i_data_ready (b_out_ready)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW:0]   exp_q[$];   // {last, data}
  logic [DW-1:0] part_q[$];
  logic          part_br;

  function automatic int rev_index(input int i, input int log2n);
    int r = 0;
    int v = i;
    for (int k = 0; k < log2n; k++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic          s_ivalid, s_iready, s_bitrev, s_ovalid, s_oready, s_olast;
  logic [DW-1:0] s_idata, s_odata;
  logic          h_valid = 1'b0;
  logic [DW-1:0] h_data;
  logic          h_last;
  int            cyc = 0;
  int            out_total = 0;
  int            acc_total = 0;
  int            last_acc_cyc = -1;
  int            out_cyc_q[$];

  initial forever begin
    @(negedge clk);
    s_ivalid = in_valid;  s_iready = in_ready;  s_idata = in_data;  s_bitrev = in_bitrev;
    s_ovalid = out_valid; s_oready = out_ready; s_odata = out_data; s_olast  = out_last;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      h_valid = 1'b0;
    end else begin
      if (h_valid) begin
        check("hold_valid", 64'(s_ovalid), 64'd1);
        check("hold_data",  64'(s_odata),  64'(h_data));
        check("hold_last",  64'(s_olast),  64'(h_last));
      end
      h_valid = s_ovalid && !s_oready;
      h_data  = s_odata;
      h_last  = s_olast;

      if (s_ivalid && s_iready) begin
        acc_total++;
        if (part_q.size() == 0) part_br = s_bitrev;
        part_q.push_back(s_idata);
        if (part_q.size() == N) begin
          last_acc_cyc = cyc;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = part_br ? rev_index(k, LOG2N) : k;
            exp_q.push_back({(k == N - 1), part_q[idx]});
          end
          part_q.delete();
        end
      end

      if (s_ovalid && s_oready) begin
        out_total++;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %0h, expected no output", s_odata);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("out_data", 64'(s_odata), 64'(e[DW-1:0]));
          check("out_last", 64'(s_olast), 64'(e[DW]));
        end
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks ----------------
  int stall_total = 0;

  task automatic send(input logic [DW-1:0] d, input logic br, input int max_gap);
    int  g;
    int  waited;
    logic acc;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_bitrev = br;
    waited    = 0;
    acc       = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        stall_total++;
        if (waited > TMO) begin
          check("send_timeout", 64'(waited), 64'(0));
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input logic br);
    for (int k = 0; k < N; k++) send(DW'(base + k), br, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input int n);
    idle();
    rst_n = 1'b0;
    cycles(n);
    rst_n = 1'b1;
    check("rst_ready", 64'(in_ready),  64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last",  64'(out_last),  64'd0);
    check("rst_data",  64'(out_data),  64'd0);
  endtask

  // ---------------- second-instance checker ----------------
  logic [15:0] b_order [16];
  int          b_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (b_rst_n && b_out_valid && b_out_ready) begin
      if (b_cnt < 16) begin
        check("p16_data", 64'(b_out_data), 64'(b_order[b_cnt]));
        check("p16_last", 64'(b_out_last), 64'(b_cnt == 15));
      end else begin
        tests++;
        fails++;
        $display("FAIL p16_extra: got %0h, expected no output", b_out_data);
      end
      b_cnt++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout: got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bitrev = 1'b0; out_ready = 1'b1;
    b_rst_n = 1'b0; b_valid = 1'b0; b_data = '0; b_bitrev = 1'b0; b_out_ready = 1'b1;
    b_order = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};
    @(posedge clk);
    #1;
    do_reset(3);

    // 1: single bit-reversed frame, check latency of first output
    out_cyc_q.delete();
    send_frame(0, 1'b1);
    idle();
    wait_drain();
    check("t1_count", 64'(out_cyc_q.size()), 64'd8);
    if (out_cyc_q.size() > 0)
      check("t1_latency", 64'(out_cyc_q[0] - last_acc_cyc), 64'd2);

    // 2: back-to-back frames, no input stalls, no output gaps
    out_cyc_q.delete();
    stall_total = 0;
    send_frame(0, 1'b0);
    send_frame(8, 1'b1);
    idle();
    wait_drain();
    check("t2_stalls", 64'(stall_total), 64'd0);
    check("t2_count", 64'(out_cyc_q.size()), 64'd16);
    if (out_cyc_q.size() == 16)
      check("t2_no_gap", 64'(out_cyc_q[15] - out_cyc_q[0]), 64'd15);

    // 3: back-pressure fills both banks
    ready_mode = 1;
    cycles(1);
    begin
      int base_acc;
      base_acc = acc_total;
      for (int k = 0; k < 16; k++) send(DW'(k), 1'b0, 0);
      idle();
      cycles(3);
      check("t3_ready_low", 64'(in_ready), 64'd0);
      check("t3_valid_held", 64'(out_valid), 64'd1);
      check("t3_data_held", 64'(out_data), 64'd0);
      fork
        begin
          for (int k = 16; k < 24; k++) send(DW'(k), 1'b0, 0);
          idle();
        end
        begin
          cycles(5);
          check("t3_still_low", 64'(in_ready), 64'd0);
          check("t3_acc_16", 64'(acc_total - base_acc), 64'd16);
          ready_mode = 0;
        end
      join
      wait_drain();
      check("t3_ready_back", 64'(in_ready), 64'd1);
    end

    // 4: random traffic on both sides
    ready_mode = 2;
    for (int f = 0; f < 100; f++) begin
      logic br;
      br = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        logic [DW-1:0] d;
        d = DW'(pack_sample(32'($urandom), 32'($urandom), DW));
        send(d, (k == 0) ? br : 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 2 : 0);
      end
    end
    idle();
    ready_mode = 0;
    wait_drain();

    // 5a: reset after 5 input samples
    for (int k = 0; k < 5; k++) send(DW'(100 + k), 1'b1, 0);
    do_reset(2);
    send_frame(0, 1'b1);
    idle();
    wait_drain();

    // 5b: reset after 3 outputs
    begin
      int target;
      int n;
      target = out_total + 3;
      send_frame(40, 1'b0);
      idle();
      n = 0;
      while (out_total < target && n < TMO) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("t5_three_out", 64'(out_total >= target), 64'd1);
      do_reset(2);
      send_frame(0, 1'b1);
      idle();
      wait_drain();
    end

    // 6: LOG2N = 4, DATA_W = 16 bit-reversed frame
    b_rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("p16_ready", 64'(b_in_ready), 64'd1);
      b_valid  = 1'b1;
      b_data   = 16'(k);
      b_bitrev = 1'b1;
      cycles(1);
    end
    b_valid = 1'b0;
    begin
      int n = 0;
      while (b_cnt < 16 && n < 200) begin
        cycles(1);
        n++;
      end
    end
    cycles(4);
    check("p16_count", 64'(b_cnt), 64'd16);

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
